al_phy_lslice_array: RTL and testbench

AL_PHY_LSLICE_ARRAY -- requirements
Module: al_phy_lslice_array

---
 rtl/al_phy_slice_pkg.sv | 22 ++
 rtl/al_phy_lut4_ram.sv | 27 ++
 rtl/al_phy_lslice_array.sv | 81 ++++++++
 tb/tb_al_phy_lslice_array.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/al_phy_slice_pkg.sv
// Shared constants for the logic-slice array: address width and the string
// values accepted by the MODE / REGSET / REG_SD / CEMUX parameters.
package al_phy_slice_pkg;

    localparam int ADDR_W    = 4;
    localparam int LUT_DEPTH = 1 << ADDR_W;

    localparam string MODE_LOGIC   = "LOGIC";
    localparam string MODE_ADDER   = "ADDER";
    localparam string MODE_RAMW    = "RAMW";

    localparam string REGSET_RESET = "RESET";
    localparam string REGSET_SET   = "SET";

    localparam string REG_SD_F     = "F";
    localparam string REG_SD_MI    = "MI";

    localparam string CEMUX_CE     = "CE";
    localparam string CEMUX_INV    = "INV";
    localparam string CEMUX_ONE    = "1";

endpackage

// File: rtl/al_phy_lut4_ram.sv
// One slice lane: 16x1 LUT/distributed-RAM cell with INIT contents, async read
// and a synchronous write port that only exists when WR_EN is set.
module al_phy_lut4_ram
    import al_phy_slice_pkg::*;
#(
    parameter logic [LUT_DEPTH-1:0] INIT  = '0,
    parameter bit                   WR_EN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wdi,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_f
);

    // Contents start at INIT and are never cleared by any reset.
    logic [LUT_DEPTH-1:0] r_mem = INIT;

    always_ff @(posedge i_clk) begin
        if (WR_EN && i_we)
            r_mem[i_waddr] <= i_wdi;
    end

    assign o_f = r_mem[i_raddr];

endmodule

// File: rtl/al_phy_lslice_array.sv
// LANES-wide logic slice: per-lane LUT4/RAM cells, a ripple carry chain for
// ADDER mode and a shared-control output register bank.
module al_phy_lslice_array
    import al_phy_slice_pkg::*;
#(
    parameter int                      LANES    = 4,
    parameter logic [LANES*16-1:0]     INIT_LUT = '0,
    parameter string                   MODE     = "LOGIC",
    parameter string                   REGSET   = "RESET",
    parameter string                   REG_SD   = "F",
    parameter string                   CEMUX    = "CE"
) (
    input  logic              clk,
    input  logic              sr,
    input  logic              ce,
    input  logic [LANES-1:0]  a,
    input  logic [LANES-1:0]  b,
    input  logic [LANES-1:0]  c,
    input  logic [LANES-1:0]  d,
    input  logic [LANES-1:0]  mi,
    input  logic              fci,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANES-1:0]  wdi,
    output logic [LANES-1:0]  f,
    output logic [LANES-1:0]  q,
    output logic              fco
);

    localparam bit IS_ADDER  = (MODE == MODE_ADDER);
    localparam bit IS_RAMW   = (MODE == MODE_RAMW);
    localparam bit SD_MI     = (REG_SD == REG_SD_MI);
    localparam bit CE_FORCE  = (CEMUX == CEMUX_ONE);
    localparam bit CE_INVERT = (CEMUX == CEMUX_INV);
    localparam logic [LANES-1:0] SR_VAL = (REGSET == REGSET_SET) ? {LANES{1'b1}} : {LANES{1'b0}};

    logic [LANES-1:0] w_lut;
    logic [LANES-1:0] w_sum;
    logic [LANES:0]   w_cy;
    logic [LANES-1:0] w_d;
    logic             w_en;

    assign w_cy[0] = fci;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        al_phy_lut4_ram #(
            .INIT  (INIT_LUT[16*gi +: 16]),
            .WR_EN (IS_RAMW)
        ) u_lut (
            .i_clk   (clk),
            .i_we    (we),
            .i_waddr (waddr),
            .i_wdi   (wdi[gi]),
            .i_raddr ({d[gi], c[gi], b[gi], a[gi]}),
            .o_f     (w_lut[gi])
        );

        assign w_sum[gi]   = a[gi] ^ b[gi] ^ w_cy[gi];
        assign w_cy[gi+1]  = (a[gi] & b[gi]) | (w_cy[gi] & (a[gi] ^ b[gi]));
    end

    // Adder mode bypasses the LUT cells entirely; c/d only reach the LUTs.
    assign f   = IS_ADDER ? w_sum : w_lut;
    assign fco = IS_ADDER & w_cy[LANES];

    assign w_d  = SD_MI ? mi : f;
    assign w_en = CE_FORCE | (ce ^ CE_INVERT);

    // Power-up value 0 until the first sr; sr beats the clock enable.
    logic [LANES-1:0] r_q = '0;

    always_ff @(posedge clk) begin
        if (sr)
            r_q <= SR_VAL;
        else if (w_en)
            r_q <= w_d;
    end

    assign q = r_q;

endmodule

// File: tb/tb_al_phy_lslice_array.sv
// Scoreboard bench: four slice configurations share one stimulus bus; the
// stimulus thread queues expected values and a negedge monitor checks them.
module tb_al_phy_lslice_array;

    localparam int SEL_LF  = 0;  // logic slice f
    localparam int SEL_LQ  = 1;  // logic slice q
    localparam int SEL_LCO = 2;  // logic slice fco
    localparam int SEL_SQ  = 3;  // SET/MI/INV slice q
    localparam int SEL_AF  = 4;  // adder {fco,f}
    localparam int SEL_RF  = 5;  // RAM slice f
    localparam int SEL_RQ  = 6;  // RAM slice q

    localparam logic [63:0] INIT_LG = {16'hAAAA, 16'h0000, 16'hFFFF, 16'h8000};
    localparam logic [63:0] INIT_RM = {16'h0008, 16'h0008, 16'h0008, 16'h0008};

    typedef struct {
        string      name;
        int         sel;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       sr = 1'b0, ce = 1'b0, fci = 1'b0, we = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0, d = '0, mi = '0, wdi = '0, waddr = '0;

    logic [3:0] f_lg, q_lg, f_st, q_st, f_ad, q_ad, f_rm, q_rm;
    logic       fco_lg, fco_st, fco_ad, fco_rm;

    always #5 clk = ~clk;

    al_phy_lslice_array #(.LANES(4), .INIT_LUT(INIT_LG), .MODE("LOGIC"),
        .REGSET("RESET"), .REG_SD("F"), .CEMUX("CE")) u_lg (
        .clk(clk), .sr(sr), .ce(ce), .a(a), .b(b), .c(c), .d(d), .mi(mi),
        .fci(fci), .we(we), .waddr(waddr), .wdi(wdi),
        .f(f_lg), .q(q_lg), .fco(fco_lg));

    al_phy_lslice_array #(.LANES(4), .INIT_LUT(INIT_LG), .MODE("LOGIC"),
        .REGSET("SET"), .REG_SD("MI"), .CEMUX("INV")) u_st (
        .clk(clk), .sr(sr), .ce(ce), .a(a), .b(b), .c(c), .d(d), .mi(mi),
        .fci(fci), .we(we), .waddr(waddr), .wdi(wdi),
        .f(f_st), .q(q_st), .fco(fco_st));

    al_phy_lslice_array #(.LANES(4), .MODE("ADDER")) u_ad (
        .clk(clk), .sr(sr), .ce(ce), .a(a), .b(b), .c(c), .d(d), .mi(mi),
        .fci(fci), .we(we), .waddr(waddr), .wdi(wdi),
        .f(f_ad), .q(q_ad), .fco(fco_ad));

    al_phy_lslice_array #(.LANES(4), .INIT_LUT(INIT_RM), .MODE("RAMW"),
        .REGSET("RESET"), .REG_SD("F"), .CEMUX("CE")) u_rm (
        .clk(clk), .sr(sr), .ce(ce), .a(a), .b(b), .c(c), .d(d), .mi(mi),
        .fci(fci), .we(we), .waddr(waddr), .wdi(wdi),
        .f(f_rm), .q(q_rm), .fco(fco_rm));

    function automatic logic [4:0] pick(input int sel);
        case (sel)
            SEL_LF:  pick = {1'b0, f_lg};
            SEL_LQ:  pick = {1'b0, q_lg};
            SEL_LCO: pick = {4'b0, fco_lg};
            SEL_SQ:  pick = {1'b0, q_st};
            SEL_AF:  pick = {fco_ad, f_ad};
            SEL_RF:  pick = {1'b0, f_rm};
            SEL_RQ:  pick = {1'b0, q_rm};
            default: pick = 5'bxxxxx;
        endcase
    endfunction

    // Monitor: everything queued since the last check is due at this edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [4:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [3:0] va, input logic [3:0] vb,
                           input logic vci, input logic [4:0] exp);
        a = va; b = vb; fci = vci;
        expect_v(name, SEL_AF, exp);
        expect_v({name, "_lgfco"}, SEL_LCO, 5'h00);
        tick();
    endtask

    initial begin
        // Power-up: no sr seen yet, so both registers read 0.
        expect_v("pwrup_lq", SEL_LQ, 5'h0);
        expect_v("pwrup_sq", SEL_SQ, 5'h0);
        tick();

        // sr with ce=0: SET slice goes to all ones, RESET slice to zero.
        sr = 1'b1; ce = 1'b0;
        tick();
        expect_v("sr_set_sq", SEL_SQ, 5'hF);
        expect_v("sr_rst_lq", SEL_LQ, 5'h0);

        // Index F on lane0 (8000 -> 1), index 0 elsewhere: lanes = {0,0,1,1}.
        sr = 1'b0; ce = 1'b1; a = 4'h1; b = 4'h1; c = 4'h1; d = 4'h1;
        expect_v("lut_idx15_lf", SEL_LF, 5'h3);
        tick();
        expect_v("lut_idx15_lq", SEL_LQ, 5'h3);
        expect_v("inv_hold1_sq", SEL_SQ, 5'hF);

        // lane0 idx E -> 0, lane1 idx1 -> 1, lane2 -> 0, lane3 idx1 of AAAA -> 1.
        a = 4'hE;
        expect_v("lut_mix_lf", SEL_LF, 5'hA);
        tick();
        expect_v("lut_mix_lq", SEL_LQ, 5'hA);
        expect_v("inv_hold2_sq", SEL_SQ, 5'hF);
        tick();
        expect_v("inv_hold3_sq", SEL_SQ, 5'hF);

        // ce=0: INV slice loads mi, CE slice holds.
        ce = 1'b0; mi = 4'h6;
        tick();
        expect_v("inv_load_sq", SEL_SQ, 5'h6);
        expect_v("ce0_hold_lq", SEL_LQ, 5'hA);

        // sr glitch that is gone before the edge must do nothing.
        sr = 1'b1; #2; sr = 1'b0;
        tick();
        expect_v("srglitch_lq", SEL_LQ, 5'hA);
        expect_v("srglitch_sq", SEL_SQ, 5'h6);

        // we in LOGIC mode is ignored; the RAM slice writes D at address 0.
        a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0;
        we = 1'b1; waddr = 4'h0; wdi = 4'hD;
        expect_v("logic_we_pre_lf", SEL_LF, 5'h2);
        expect_v("ram_a0_old_rf", SEL_RF, 5'h0);
        tick();
        we = 1'b0;
        expect_v("logic_we_post_lf", SEL_LF, 5'h2);
        expect_v("ram_a0_new_rf", SEL_RF, 5'hD);
        tick();

        // Write A at address 3 while reading it: q keeps the old F.
        ce = 1'b1; a = 4'hF; b = 4'hF; c = 4'h0; d = 4'h0;
        we = 1'b1; waddr = 4'h3; wdi = 4'hA;
        expect_v("ram_a3_old_rf", SEL_RF, 5'hF);
        tick();
        expect_v("ram_rw_old_rq", SEL_RQ, 5'hF);
        we = 1'b0;
        expect_v("ram_a3_new_rf", SEL_RF, 5'hA);
        tick();
        expect_v("ram_a3_new_rq", SEL_RQ, 5'hA);

        // sr clears q but leaves RAM contents alone.
        sr = 1'b1;
        tick();
        sr = 1'b0;
        expect_v("sr_keep_ram_rf", SEL_RF, 5'hA);
        expect_v("sr_clr_rq", SEL_RQ, 5'h0);
        tick();

        // Adder, with c/d driven to non-zero to show they are ignored.
        c = 4'hF; d = 4'h5;
        add_vec("add_f_1",    4'hF, 4'h1, 1'b0, 5'h10);
        add_vec("add_5_2_ci", 4'h5, 4'h2, 1'b1, 5'h08);
        add_vec("add_0_0_ci", 4'h0, 4'h0, 1'b1, 5'h01);
        add_vec("add_f_f_ci", 4'hF, 4'hF, 1'b1, 5'h1F);
        add_vec("add_a_5",    4'hA, 4'h5, 1'b0, 5'h0F);

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
